// File: rtl/n_pkg.sv
// Shared types for the round-robin arbiter.
// Holds the controller state enum and defaults.
package n_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    GNT  = 1'b1
  } state_e;

endpackage

// File: rtl/n_nxt_one.sv
// Cyclic first-one finder: picks the first set bit
// of x_i at or after pos_i, wrapping to bit 0.
module n_nxt_one
  import n_pkg::*;
#(
  parameter int W  = N_DEFAULT,
  parameter int PW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  x_i,
  input  logic [PW-1:0] pos_i,
  output logic [W-1:0]  y_o
);

  logic [W-1:0] m;
  logic [W-1:0] hi;
  logic [W-1:0] sel;

  always_comb begin
    m = '0;
    for (int i = 0; i < W; i++) begin
      m[i] = (i >= int'(pos_i));
    end
  end

  // Upper segment wins; otherwise wrap to the full vector.
  assign hi  = x_i & m;
  assign sel = (|hi) ? hi : x_i;
  assign y_o = sel & (~sel + W'(1));

endmodule

// File: rtl/n_rr_arb.sv
// Registered round-robin arbiter with a valid/ready
// grant output and back-to-back grants on accept.
module n_rr_arb
  import n_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [N-1:0]     req_i,
  input  logic             rdy_i,
  output logic             vld_o,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] spos;
  logic [N-1:0]     hit;
  logic             acc;

  always_comb begin
    idx = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_q[k]) idx = idx | IDX_W'(k);
    end
  end

  // Explicit wrap keeps non-power-of-two N legal.
  assign ptr_nxt = (idx == IDX_W'(N - 1)) ? '0
                 : idx + IDX_W'(1);
  assign acc     = (state_q == GNT) && rdy_i;
  assign spos    = acc ? ptr_nxt : ptr_q;

  n_nxt_one #(
    .W  (N),
    .PW (IDX_W)
  ) u_nxt (
    .x_i   (req_i),
    .pos_i (spos),
    .y_o   (hit)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_d   = hit;
          state_d = GNT;
        end
      end
      GNT: begin
        if (rdy_i) begin
          ptr_d = ptr_nxt;
          if (|req_i) begin
            gnt_d = hit;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  assign vld_o     = (state_q == GNT);
  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx;

endmodule

// File: tb/tb_n_rr_arb.sv
// Bench for n_rr_arb: directed scenarios plus random
// traffic against a cyclic-priority reference model.
module tb_n_rr_arb;

  localparam int N = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic [N-1:0]  req_i = '0;
  logic          rdy_i = 1'b0;
  logic          vld_o;
  logic [N-1:0]  gnt_o;
  logic [IW-1:0] gnt_idx_o;

  int checks = 0;
  int failures = 0;

  int m_ptr = 0;
  bit m_vld = 1'b0;
  int m_idx = 0;

  n_rr_arb #(.N(N), .IDX_W(IW)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .req_i     (req_i),
    .rdy_i     (rdy_i),
    .vld_o     (vld_o),
    .gnt_o     (gnt_o),
    .gnt_idx_o (gnt_idx_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int first_from(
      input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic model_clock();
    int f;
    if (!m_vld) begin
      f = first_from(req_i, m_ptr);
      if (f >= 0) begin
        m_vld = 1'b1;
        m_idx = f;
      end
    end else if (rdy_i) begin
      m_ptr = (m_idx + 1) % N;
      f = first_from(req_i, m_ptr);
      if (f >= 0) m_idx = f;
      else m_vld = 1'b0;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_vld"}, 64'(vld_o), 64'(m_vld));
    chk({tag, "_gnt"}, 64'(gnt_o),
        m_vld ? (64'(1) << m_idx) : 64'(0));
    chk({tag, "_idx"}, 64'(gnt_idx_o),
        m_vld ? 64'(m_idx) : 64'(0));
  endtask

  task automatic step(input logic [N-1:0] r,
                      input logic rd);
    @(negedge clk);
    req_i = r;
    rdy_i = rd;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk({tag, "_rst_vld"}, 64'(vld_o), 64'(0));
    chk({tag, "_rst_gnt"}, 64'(gnt_o), 64'(0));
    chk({tag, "_rst_idx"}, 64'(gnt_idx_o), 64'(0));
    m_ptr = 0;
    m_vld = 1'b0;
    m_idx = 0;
    req_i = '0;
    rdy_i = 1'b0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    do_reset("init");

    for (int i = 0; i < 10; i++) begin
      step(8'h00, 1'b0);
      chk("idle_vld", 64'(vld_o), 64'(0));
      chk("idle_gnt", 64'(gnt_o), 64'(0));
      chk("idle_idx", 64'(gnt_idx_o), 64'(0));
    end

    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b1);
      chk("full_idx", 64'(gnt_idx_o), 64'(i % 8));
      chk_model("full");
    end

    do_reset("fair");
    for (int i = 0; i < 4; i++) begin
      step(8'h81, 1'b1);
      chk("fair_gnt", 64'(gnt_o),
          (i % 2 == 0) ? 64'h01 : 64'h80);
    end

    do_reset("bp");
    step(8'h06, 1'b0);
    chk("bp_first", 64'(gnt_o), 64'h02);
    step(8'h06, 1'b0);
    chk("bp_hold0", 64'(gnt_o), 64'h02);
    step(8'h04, 1'b0);
    chk("bp_hold1", 64'(gnt_o), 64'h02);
    step(8'h04, 1'b0);
    chk("bp_hold2", 64'(gnt_o), 64'h02);
    chk("bp_idx", 64'(gnt_idx_o), 64'd1);
    step(8'h04, 1'b1);
    chk("bp_next", 64'(gnt_o), 64'h04);
    chk_model("bp");

    do_reset("wrap");
    step(8'h40, 1'b1);
    chk("wrap_g6", 64'(gnt_idx_o), 64'd6);
    step(8'h41, 1'b1);
    chk("wrap_idx", 64'(gnt_idx_o), 64'd0);
    chk_model("wrap");

    do_reset("mid");
    step(8'h10, 1'b0);
    chk("mid_pre", 64'(gnt_o), 64'h10);
    do_reset("mid");
    step(8'h30, 1'b0);
    chk("mid_post", 64'(gnt_o), 64'h10);
    chk_model("mid");

    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      r = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      else if ($urandom_range(0, 2) == 0)
        r = r & N'($urandom);
      step(r, 1'($urandom_range(0, 1)));
      chk_model("rand");
      if (i == 200) do_reset("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/n_rr_arb.md
N_RR_ARB -- requirements
Module: n_rr_arb

Interface
REQ-001 SHALL have parameter N, default 8: number of requesters; legal range 2..64.
REQ-002 SHALL have parameter IDX_W, default $clog2(N): width of the encoded grant index.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port arst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port req_i, input, N: request vector, bit k = requester k.
REQ-006 SHALL have port rdy_i, input, 1: consumer accepts the presented grant.
REQ-007 SHALL have port vld_o, output, 1: a grant is presented.
REQ-008 SHALL have port gnt_o, output, N: one-hot grant, all-zero when vld_o=0.
REQ-009 SHALL have port gnt_idx_o, output, IDX_W: binary index of gnt_o, zero when vld_o=0.

Function
REQ-010 SHALL hold pointer ptr (IDX_W bits, range 0..N-1): the highest-priority position for the next search.
REQ-011 SHALL select the first set bit of req_i at position ptr, ptr+1, ..., N-1, 0, ..., ptr-1, wrapping cyclically.
REQ-012 SHALL implement two states: IDLE (vld_o=0) and GNT (vld_o=1, grant registered).
REQ-013 SHALL, in IDLE with req_i nonzero, load the selected grant and enter GNT; vld_o rises exactly 1 cycle after req_i is sampled.
REQ-014 SHALL, in IDLE with req_i zero, remain in IDLE with ptr unchanged.
REQ-015 SHALL, in GNT with rdy_i=0, hold gnt_o, gnt_idx_o and ptr stable, regardless of changes on req_i (grant is committed).
REQ-016 SHALL, on accept (vld_o=1 and rdy_i=1) of index k, set ptr to (k+1) mod N; the wrap from N-1 to 0 is explicit and valid for non-power-of-two N.
REQ-017 SHALL, in the accept cycle, search req_i from the updated ptr:
- nonzero result: load the new grant and stay in GNT, giving back-to-back grants at 1 per cycle;
- zero result: go to IDLE.
REQ-018 SHALL, in the accept search, give the just-accepted requester k lowest priority if its req_i bit is still set.
REQ-019 SHALL keep gnt_o one-hot or zero, and keep gnt_idx_o consistent with gnt_o, in every cycle.
REQ-020 SHALL have no combinational path from req_i or rdy_i to any output.

Reset
REQ-021 SHALL, while arst_n=0, force state=IDLE, ptr=0, vld_o=0, gnt_o=0 and gnt_idx_o=0, taking effect immediately without waiting for clk.
REQ-022 SHALL discard a pending grant on reset mid-operation, with no accept implied.
REQ-023 SHALL treat the first clk edge after arst_n deasserts as an IDLE-state evaluation.

Structure
REQ-024 SHALL place the state enum (IDLE, GNT) in the shared package n_pkg.
REQ-025 SHALL implement the cyclic search in one combinational sub-module, n_nxt_one: parameter W; inputs x_i[W] and pos_i; output one-hot y_o, which is the first set bit at or after pos_i, cyclically.
REQ-026 SHALL encode gnt_idx_o from the one-hot result with a plain one-hot-to-binary OR reduction.

Verification (N=8)
REQ-027 Idle: after reset, req_i=0x00 for 10 cycles -> vld_o=0, gnt_o=0x00, gnt_idx_o=0 throughout.
REQ-028 Full load: req_i=0xFF, rdy_i=1 steady -> gnt_idx_o = 0,1,2,...,7,0 on consecutive cycles, with the first grant 1 cycle after the first req.
REQ-029 Fairness: req_i=0x81, rdy_i=1 steady -> gnt_o alternates 0x01, 0x80, 0x01, 0x80.
REQ-030 Backpressure: req_i=0x06, rdy_i=0 for 3 cycles -> gnt_o=0x02 held stable even when req_i drops to 0x04; then rdy_i=1 for 1 cycle -> next cycle gnt_o=0x04.
REQ-031 Wrap: accept index 6 so that ptr=7, then req_i=0x41 -> gnt_idx_o=0, not 6.
REQ-032 Reset mid-grant: arst_n=0 while vld_o=1 and gnt_o=0x10 -> vld_o and gnt_o=0 before the next clk edge; after release with req_i=0x30 -> gnt_o=0x10, because ptr=0.
